// File: rtl/rf_load_ctrl_if.sv
// Row-load bus between rf_load_ctrl and its environment: input row stream,
// register-file write port and multiplier launch/complete handshake.
interface rf_load_ctrl_if #(
    parameter int WIDTH = 8
);
    // Row stream: a row transfers on every rising edge where in_valid && in_ready.
    // in_valid and in_data come from the source; in_ready comes from the controller.
    // The controller raises in_ready only in LOAD, independent of in_valid.
    logic                 in_valid;
    logic                 in_ready;
    logic [8*WIDTH-1:0]   in_data;
    logic                 rf_enable;
    logic                 rf_write;
    logic [2:0]           rf_idx;
    logic [8*WIDTH-1:0]   rf_data;
    logic                 mac_start;
    logic                 mac_done;

    modport master (
        input  in_valid, in_data, mac_done,
        output in_ready, rf_enable, rf_write, rf_idx, rf_data, mac_start
    );

    modport slave (
        output in_valid, in_data, mac_done,
        input  in_ready, rf_enable, rf_write, rf_idx, rf_data, mac_start
    );
endinterface

// File: rtl/rf_load_ctrl.sv
// Loads ROWS rows into a register file, launches the multiply and waits for it.
// Optional WAIT watchdog with sticky error flag: define RF_LOAD_TIMEOUT_EN.
module rf_load_ctrl #(
    parameter int ROWS    = 8,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    rf_load_ctrl_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    state_dbg
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    if (ROWS < 1 || ROWS > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("rf_load_ctrl: ROWS must be 1..8 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] row_cnt;
    logic          handshake;
    logic          wr;
    logic          accept;
    logic          timeout;

    assign handshake = bus.in_valid && (state == LOAD);
    // A handshake that coincides with abort is dropped, so it never writes.
    assign wr        = handshake && !abort;
    assign accept    = (state == IDLE) && start && !abort;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.mac_start = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD: begin
                bus.in_ready = 1'b1;
                if (handshake && row_cnt == LAST_ROW) state_next = START;
            end
            START: begin
                bus.mac_start = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                if (bus.mac_done)  state_next = DONE;
                else if (timeout)  state_next = IDLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt       <= '0;
            bus.rf_enable <= 1'b0;
            bus.rf_write  <= 1'b0;
            bus.rf_idx    <= 3'd0;
            bus.rf_data   <= '0;
        end else begin
            bus.rf_enable <= wr;
            bus.rf_write  <= wr;
            if (wr) begin
                bus.rf_idx  <= 3'(row_cnt);
                bus.rf_data <= bus.in_data;
            end
            // The last row leaves row_cnt at ROWS-1; the next start clears it.
            if (abort || accept)
                row_cnt <= '0;
            else if (wr && row_cnt != LAST_ROW)
                row_cnt <= row_cnt + 1'b1;
        end
    end

`ifdef RF_LOAD_TIMEOUT_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WDW-1:0] watchdog;

    // The TIMEOUT-th WAIT cycle without mac_done gives up on the multiplier.
    assign timeout = (state == WAIT) && !bus.mac_done && (watchdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watchdog <= '0;
            error    <= 1'b0;
        end else begin
            if (state == START)     watchdog <= '0;
            else if (state == WAIT) watchdog <= watchdog + 1'b1;
            if (!abort) begin
                if (timeout)     error <= 1'b1;
                else if (accept) error <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_load_ctrl.sv
// Directed bench for rf_load_ctrl: reset, streaming, stalls, abort, ignored
// control inputs, mid-job reset and the WAIT watchdog (or its absence).
module tb_rf_load_ctrl;
    localparam int ROWS  = 8;
    localparam int WIDTH = 8;
`ifdef RF_LOAD_TIMEOUT_EN
    localparam int TIMEOUT = 15;
`else
    localparam int TIMEOUT = 1023;
`endif
    localparam int DW = 8 * WIDTH;
    localparam int EW = DW + 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd3;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, error;
    logic [2:0] state_dbg;

    rf_load_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rf_load_ctrl #(.ROWS(ROWS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int            wr_cyc_q[$];
    int            ms_cnt = 0, done_cnt = 0, ms_cyc = 0, done_cyc = 0;
    int            errors = 0, checks = 0;

    always @(negedge clk) begin
        if (bus.rf_write) begin
            got_q.push_back({bus.rf_idx, bus.rf_data});
            wr_cyc_q.push_back(cyc);
        end
        if (bus.mac_start) begin
            ms_cnt <= ms_cnt + 1;
            ms_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    function automatic logic [DW-1:0] mk(input int v);
        logic [WIDTH-1:0] e;
        e = WIDTH'(v);
        return {8{e}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic drive_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive_rows(input int first, input int n, input int base, input int gap);
        for (int r = first; r < first + n; r++) begin
            if (r > first) begin
                bus.in_valid = 1'b0;
                repeat (gap) step();
            end
            exp_q.push_back({3'(r), mk(base + r)});
            bus.in_valid = 1'b1;
            bus.in_data  = mk(base + r);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_mac(input int delay);
        repeat (delay) step();
        bus.mac_done = 1'b1;
        step();
        bus.mac_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: observed=%0d expected=0", state_dbg); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: observed=%b expected=0", bus.in_ready); end
        checks++; if ({bus.rf_enable, bus.rf_write, bus.mac_start} !== 3'b000) begin errors++; $display("FAIL reset_strobes: observed=%b expected=000", {bus.rf_enable, bus.rf_write, bus.mac_start}); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: observed=%b expected=000", {busy, done, error}); end
        checks++; if ({bus.rf_idx, bus.rf_data} !== '0) begin errors++; $display("FAIL reset_rf: observed=%0h expected=0", {bus.rf_idx, bus.rf_data}); end
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: observed=%b expected=0", busy); end
    endtask

    task automatic test_basic();
        int c0, d0;
        clear_sb();
        d0 = done_cnt;
        c0 = cyc;
        drive_start();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: observed=%b expected=1", bus.in_ready); end
        drive_rows(0, ROWS, 0, 0);
        checks++; if ({bus.mac_start, bus.rf_write, bus.rf_idx} !== {2'b11, 3'd7}) begin errors++; $display("FAIL basic_last_write: observed=%0h expected=%0h", {bus.mac_start, bus.rf_write, bus.rf_idx}, {2'b11, 3'd7}); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: observed=%b expected=0", bus.in_ready); end
        drive_mac(5);
        checks++; if ({done, busy} !== 2'b11) begin errors++; $display("FAIL basic_done: observed=%b expected=11", {done, busy}); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle: observed=%b expected=00", {done, busy}); end
        checks++; if (ms_cyc !== c0 + 9) begin errors++; $display("FAIL basic_mac_cycle: observed=%0d expected=%0d", ms_cyc, c0 + 9); end
        checks++; if (done_cyc !== c0 + ROWS + 3 + 4) begin errors++; $display("FAIL basic_latency: observed=%0d expected=%0d", done_cyc, c0 + ROWS + 7); end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done_count: observed=%0d expected=%0d", done_cnt, d0 + 1); end
        checks++; if (wr_cyc_q.size() !== ROWS || wr_cyc_q[ROWS-1] - wr_cyc_q[0] !== ROWS - 1) begin errors++; $display("FAIL basic_consecutive: observed=%0d writes expected=%0d", wr_cyc_q.size(), ROWS); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: observed=%0d expected=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_row%0d: observed=%0h expected=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        clear_sb();
        drive_start();
        drive_rows(0, ROWS, 'h10, 2);
        checks++; if (bus.mac_start !== 1'b1) begin errors++; $display("FAIL stall_mac_start: observed=%b expected=1", bus.mac_start); end
        drive_mac(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: observed=%b expected=1", done); end
        step();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: observed=%0d expected=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_row%0d: observed=%0h expected=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int d0;
        clear_sb();
        d0 = done_cnt;
        drive_start();
        drive_rows(0, 3, 'h20, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk('h23);
        abort        = 1'b1;
        step();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if ({busy, bus.in_ready, bus.rf_write} !== 3'b000) begin errors++; $display("FAIL abort_idle: observed=%b expected=000", {busy, bus.in_ready, bus.rf_write}); end
        step();
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL abort_writes: observed=%0d expected=3", got_q.size()); end
        clear_sb();
        drive_start();
        drive_rows(0, ROWS, 'h30, 0);
        drive_mac(2);
        step();
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL abort_done_count: observed=%0d expected=%0d", done_cnt, d0 + 1); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_restart_count: observed=%0d expected=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_restart_row%0d: observed=%0h expected=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore();
        int d0;
        clear_sb();
        d0 = done_cnt;
        drive_start();
        drive_rows(0, 2, 'h50, 0);
        bus.mac_done = 1'b1;
        step();
        bus.mac_done = 1'b0;
        checks++; if (state_dbg !== ST_LOAD) begin errors++; $display("FAIL ignore_mac_in_load: observed=%0d expected=%0d", state_dbg, ST_LOAD); end
        drive_rows(2, ROWS - 2, 'h50, 0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (state_dbg !== ST_WAIT) begin errors++; $display("FAIL ignore_start_in_wait: observed=%0d expected=%0d", state_dbg, ST_WAIT); end
        drive_mac(0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: observed=%b expected=1", done); end
        repeat (4) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: observed=%b expected=0", busy); end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ignore_done_count: observed=%0d expected=%0d", done_cnt, d0 + 1); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ignore_count: observed=%0d expected=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ignore_row%0d: observed=%0h expected=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int m0, d0;
        clear_sb();
        m0 = ms_cnt;
        d0 = done_cnt;
        drive_start();
        drive_rows(0, 5, 'h60, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk('h65);
        rst_n        = 1'b0;
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        checks++; if ({busy, done, error, bus.in_ready, bus.rf_enable, bus.rf_write, bus.mac_start} !== 7'b0) begin errors++; $display("FAIL midrst_flags: observed=%b expected=0000000", {busy, done, error, bus.in_ready, bus.rf_enable, bus.rf_write, bus.mac_start}); end
        checks++; if ({bus.rf_idx, bus.rf_data} !== '0) begin errors++; $display("FAIL midrst_rf: observed=%0h expected=0", {bus.rf_idx, bus.rf_data}); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL midrst_state: observed=%0d expected=0", state_dbg); end
        repeat (15) step();
        checks++; if ({ms_cnt, done_cnt} !== {m0, d0}) begin errors++; $display("FAIL midrst_no_pulses: observed=%0d/%0d expected=%0d/%0d", ms_cnt, done_cnt, m0, d0); end
    endtask

    task automatic test_timeout();
        int d0;
        clear_sb();
        d0 = done_cnt;
        drive_start();
        drive_rows(0, ROWS, 'h70, 0);
        step();
`ifdef RF_LOAD_TIMEOUT_EN
        repeat (TIMEOUT - 1) step();
        checks++; if ({busy, error} !== 2'b10) begin errors++; $display("FAIL timeout_last_wait: observed=%b expected=10", {busy, error}); end
        step();
        checks++; if ({busy, error} !== 2'b01) begin errors++; $display("FAIL timeout_fire: observed=%b expected=01", {busy, error}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_abort_keeps: observed=%b expected=1", error); end
        drive_start();
        checks++; if ({state_dbg, error} !== {ST_LOAD, 1'b0}) begin errors++; $display("FAIL timeout_start_clears: observed=%0h expected=%0h", {state_dbg, error}, {ST_LOAD, 1'b0}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
`else
        repeat (40) step();
        checks++; if ({state_dbg, error} !== {ST_WAIT, 1'b0}) begin errors++; $display("FAIL nowatchdog_wait: observed=%0h expected=%0h", {state_dbg, error}, {ST_WAIT, 1'b0}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({busy, error} !== 2'b00) begin errors++; $display("FAIL nowatchdog_abort: observed=%b expected=00", {busy, error}); end
`endif
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL timeout_no_done: observed=%0d expected=%0d", done_cnt, d0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mac_done = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_ignore();
        test_mid_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: observed=stuck expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
